// File: rtl/controle_vez_pkg.sv
// Shared types and codes for the tic-tac-toe turn controller.
// Player/result codes, FSM state encoding and small helpers.
package controle_vez_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    VEZ_J1 = 3'd1,
    VEZ_J2 = 3'd2,
    ERRO   = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic [1:0] JOG_NENHUM = 2'b00;
  localparam logic [1:0] JOG_1      = 2'b01;
  localparam logic [1:0] JOG_2      = 2'b10;
  localparam logic [1:0] JOG_ERRO   = 2'b11;
  localparam logic [1:0] EMPATE     = 2'b11;

  function automatic int maximo(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] outro(logic [1:0] j);
    return (j == JOG_1) ? JOG_2 : JOG_1;
  endfunction

endpackage

// File: rtl/controle_vez_contador_m.sv
// Modular counter 0..M-1 with synchronous clear and count enable.
// Ports: clock, reset_n, zera, conta -> Q (value), fim (Q == M-1).
module contador_m #(
  parameter int M = 16,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] Q,
  output logic         fim
);

  assign fim = (Q == W'(M - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else if (zera) begin
      Q <= '0;
    end else if (conta) begin
      Q <= fim ? '0 : Q + W'(1);
    end
  end

endmodule

// File: rtl/controle_vez.sv
// Turn controller: sequences players, turn timeout, error hold, result.
// In: clock, reset_n, iniciar, jogada_ok, jogada_erro, vitoria.
// Out: jogador, vencedor, num_jogadas, timeout, fim (all registered).
module controle_vez
  import controle_vez_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int ERRO_CICLOS    = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada_ok,
  input  logic       jogada_erro,
  input  logic       vitoria,
  output logic [1:0] jogador,
  output logic [1:0] vencedor,
  output logic [3:0] num_jogadas,
  output logic       timeout,
  output logic       fim
);

  localparam int M = maximo(TIMEOUT_CICLOS, ERRO_CICLOS);
  localparam int W = $clog2(M);
  localparam logic [W-1:0] LIM_VEZ  = W'(TIMEOUT_CICLOS - 1);
  localparam logic [W-1:0] LIM_ERRO = W'(ERRO_CICLOS - 1);

  estado_t      estado;
  logic [1:0]   turno;
  logic [W-1:0] q;
  logic         q_fim;
  logic         em_vez;
  logic         expira;
  logic         erro_fim;
  logic         zera;
  logic         conta;

  // One timer shared by turn timing and error hold; it is cleared
  // on every state change and held at its top so it never wraps.
  contador_m #(.M(M), .W(W)) u_tempo (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (zera),
    .conta   (conta),
    .Q       (q),
    .fim     (q_fim)
  );

  always_comb begin
    em_vez   = (estado == VEZ_J1) || (estado == VEZ_J2);
    expira   = em_vez && (q == LIM_VEZ);
    erro_fim = (estado == ERRO) && (q == LIM_ERRO);
    zera     = iniciar
             | (em_vez & (jogada_ok | jogada_erro | expira))
             | erro_fim;
    conta    = (em_vez | (estado == ERRO)) & ~q_fim;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      turno       <= JOG_1;
      jogador     <= JOG_NENHUM;
      vencedor    <= JOG_NENHUM;
      num_jogadas <= '0;
      timeout     <= 1'b0;
      fim         <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (iniciar) begin
        estado      <= VEZ_J1;
        turno       <= JOG_1;
        jogador     <= JOG_1;
        vencedor    <= JOG_NENHUM;
        num_jogadas <= '0;
        fim         <= 1'b0;
      end else begin
        unique case (1'b1)
          em_vez: begin
            if (jogada_ok) begin
              num_jogadas <= num_jogadas + 4'd1;
              if (vitoria || num_jogadas == 4'd8) begin
                estado   <= FIM;
                jogador  <= JOG_NENHUM;
                fim      <= 1'b1;
                vencedor <= vitoria ? turno : EMPATE;
              end else begin
                estado  <= (turno == JOG_1) ? VEZ_J2 : VEZ_J1;
                turno   <= outro(turno);
                jogador <= outro(turno);
              end
            end else if (jogada_erro) begin
              estado  <= ERRO;
              jogador <= JOG_ERRO;
            end else if (expira) begin
              timeout <= 1'b1;
              estado  <= (turno == JOG_1) ? VEZ_J2 : VEZ_J1;
              turno   <= outro(turno);
              jogador <= outro(turno);
            end
          end
          (estado == ERRO): begin
            if (erro_fim) begin
              estado  <= (turno == JOG_1) ? VEZ_J1 : VEZ_J2;
              jogador <= turno;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controle_vez.sv
// Self-checking bench for controle_vez (TIMEOUT_CICLOS=8, ERRO_CICLOS=3).
// Directed scenarios with literal checks plus random play vs a model.
module tb_controle_vez;

  localparam int T = 8;
  localparam int E = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada_ok = 1'b0;
  logic       jogada_erro = 1'b0;
  logic       vitoria = 1'b0;
  logic [1:0] jogador;
  logic [1:0] vencedor;
  logic [3:0] num_jogadas;
  logic       timeout;
  logic       fim;

  always #5 clock = ~clock;

  controle_vez #(
    .TIMEOUT_CICLOS (T),
    .ERRO_CICLOS    (E)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .iniciar     (iniciar),
    .jogada_ok   (jogada_ok),
    .jogada_erro (jogada_erro),
    .vitoria     (vitoria),
    .jogador     (jogador),
    .vencedor    (vencedor),
    .num_jogadas (num_jogadas),
    .timeout     (timeout),
    .fim         (fim)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nome, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 turn, 2 error hold, 3 game over.
  // m_el = cycles already spent in the current phase.
  int m_fase, m_jog, m_n, m_venc, m_el, m_to;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_fase <= 0; m_jog <= 1; m_n <= 0;
      m_venc <= 0; m_el <= 0; m_to <= 0;
    end else begin
      m_to <= 0;
      if (iniciar) begin
        m_fase <= 1; m_jog <= 1; m_n <= 0; m_venc <= 0; m_el <= 0;
      end else if (m_fase == 1) begin
        if (jogada_ok) begin
          m_n <= m_n + 1;
          if (vitoria) begin
            m_venc <= m_jog; m_fase <= 3;
          end else if (m_n + 1 == 9) begin
            m_venc <= 3; m_fase <= 3;
          end else begin
            m_jog <= 3 - m_jog; m_el <= 0;
          end
        end else if (jogada_erro) begin
          m_fase <= 2; m_el <= 0;
        end else if (m_el + 1 == T) begin
          m_to <= 1; m_jog <= 3 - m_jog; m_el <= 0;
        end else begin
          m_el <= m_el + 1;
        end
      end else if (m_fase == 2) begin
        if (m_el + 1 == E) begin
          m_fase <= 1; m_el <= 0;
        end else begin
          m_el <= m_el + 1;
        end
      end
    end
  end

  function automatic int exp_jog(int f, int j);
    return (f == 1) ? j : (f == 2) ? 3 : 0;
  endfunction

  always @(negedge clock) begin
    chk("m_jogador", jogador, exp_jog(m_fase, m_jog));
    chk("m_vencedor", vencedor, m_venc);
    chk("m_num", num_jogadas, m_n);
    chk("m_timeout", timeout, m_to);
    chk("m_fim", fim, (m_fase == 3) ? 1 : 0);
  end

  task automatic step(input logic i, input logic o,
                      input logic e, input logic v);
    iniciar = i; jogada_ok = o; jogada_erro = e; vitoria = v;
    @(negedge clock);
  endtask

  task automatic zeros(input string nome);
    chk({nome, "_jog"}, jogador, 0);
    chk({nome, "_venc"}, vencedor, 0);
    chk({nome, "_num"}, num_jogadas, 0);
    chk({nome, "_to"}, timeout, 0);
    chk({nome, "_fim"}, fim, 0);
  endtask

  initial begin
    #2;
    zeros("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Two alternating moves
    step(1, 0, 0, 0); chk("t2_j0", jogador, 1); chk("t2_n0", num_jogadas, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("t2_j1", jogador, 2); chk("t2_n1", num_jogadas, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("t2_j2", jogador, 1); chk("t2_n2", num_jogadas, 2);
    chk("t2_v", vencedor, 0);

    // Error hold on J2, ok ignored during hold
    step(0, 1, 0, 0); chk("t3_j2", jogador, 2);
    step(0, 0, 1, 0); chk("t3_e1", jogador, 3);
    step(0, 1, 0, 0); chk("t3_e2", jogador, 3); chk("t3_n", num_jogadas, 3);
    step(0, 0, 0, 0); chk("t3_e3", jogador, 3);
    step(0, 0, 0, 0); chk("t3_back", jogador, 2); chk("t3_n2", num_jogadas, 3);

    // Turn expiry on J1, then a move on the expiry cycle
    step(0, 1, 0, 0); chk("t4_j1", jogador, 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0);
      chk("t4_wait_to", timeout, 0);
    end
    step(0, 0, 0, 0);
    chk("t4_to", timeout, 1); chk("t4_jog", jogador, 2);
    chk("t4_n", num_jogadas, 4);
    step(0, 0, 0, 0); chk("t4_to_off", timeout, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t4_ok_to", timeout, 0); chk("t4_ok_jog", jogador, 1);
    chk("t4_ok_n", num_jogadas, 5);

    // Async reset between edges
    step(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 zeros("t1");
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 1, 0, 0); chk("t1_idle", jogador, 0);

    // Draw after nine moves
    step(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0);
    chk("t5_fim", fim, 1); chk("t5_v", vencedor, 3);
    chk("t5_n", num_jogadas, 9); chk("t5_j", jogador, 0);
    step(0, 1, 0, 1);
    chk("t5_hold_n", num_jogadas, 9); chk("t5_hold_v", vencedor, 3);

    // J1 wins on move 5, then restart with a same-cycle move
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("t6_v", vencedor, 1); chk("t6_fim", fim, 1);
    chk("t6_n", num_jogadas, 5);
    step(1, 1, 0, 0);
    chk("t6_j", jogador, 1); chk("t6_n0", num_jogadas, 0);
    chk("t6_v0", vencedor, 0); chk("t6_f0", fim, 0);

    // Random play against the model
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0);
    end
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
